// File: rtl/full_adder_pkg.sv
// Shared constants and the redundant sum-of-products reference used by the
// full_adder self-checker.
package full_adder_pkg;

   localparam logic RST_VAL = 1'b0;

   // Canonical minterm form of the sum, kept structurally distinct from the XOR chain.
   function automatic logic sop_sum(input logic a, input logic b, input logic cin);
      return (~a & ~b &  cin) |
             (~a &  b & ~cin) |
             ( a & ~b & ~cin) |
             ( a &  b &  cin);
   endfunction

   function automatic logic sop_carry(input logic a, input logic b, input logic cin);
      return (a & b) | (a & cin) | (b & cin);
   endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// Half adder leaf: sum and carry of two bits.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder leaf for the ripple add/sub chain, with an optional
// registered side-band copy and a sticky redundant-logic self-check.
module full_adder
   import full_adder_pkg::*;
#(
   parameter bit REG_OUT = 1'b1,
   parameter bit CHECK   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout,
   output logic s_q,
   output logic cout_q,
   output logic valid_q,
   output logic err
);

   logic ha1_s;
   logic ha1_c;
   logic ha2_s;
   logic ha2_c;

   half_adder u_ha1 (
      .a (a),
      .b (b),
      .s (ha1_s),
      .c (ha1_c)
   );

   half_adder u_ha2 (
      .a (ha1_s),
      .b (cin),
      .s (ha2_s),
      .c (ha2_c)
   );

   // Carry path stays purely combinational so stages ripple without a clock.
   assign s    = ha2_s;
   assign cout = ha1_c | ha2_c;

   generate
      if (REG_OUT) begin : g_reg
         logic s_r;
         logic cout_r;
         logic valid_r;

         // Capture the result on enabled cycles; valid is a one-cycle pulse per capture.
         always_ff @(posedge clk) begin
            if (rst) begin
               s_r     <= RST_VAL;
               cout_r  <= RST_VAL;
               valid_r <= RST_VAL;
            end else if (en) begin
               s_r     <= s;
               cout_r  <= cout;
               valid_r <= 1'b1;
            end else begin
               s_r     <= s_r;
               cout_r  <= cout_r;
               valid_r <= 1'b0;
            end
         end

         assign s_q     = s_r;
         assign cout_q  = cout_r;
         assign valid_q = valid_r;
      end else begin : g_noreg
         assign s_q     = 1'b0;
         assign cout_q  = 1'b0;
         assign valid_q = 1'b0;
      end
   endgenerate

   generate
      if (CHECK) begin : g_check
         logic s_ref_s;
         logic c_ref_s;
         logic err_r;

         assign s_ref_s = sop_sum(a, b, cin);
         assign c_ref_s = sop_carry(a, b, cin);

         // Sticky mismatch flag; only reset clears it.
         always_ff @(posedge clk) begin
            if (rst) begin
               err_r <= RST_VAL;
            end else if (en && ((s != s_ref_s) || (cout != c_ref_s))) begin
               err_r <= 1'b1;
            end else begin
               err_r <= err_r;
            end
         end

         assign err = err_r;
      end else begin : g_nocheck
         assign err = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: randomized stimulus against an arithmetic
// reference model, plus a 9-bit ripple add/sub chain built from the same cell.
module tb_full_adder;

   logic clk;
   logic rst;
   logic en;
   logic a;
   logic b;
   logic cin;
   logic s;
   logic cout;
   logic s_q;
   logic cout_q;
   logic valid_q;
   logic err;

   int pass_cnt;
   int total_cnt;

   logic exp_sq;
   logic exp_cq;
   logic exp_v;

   full_adder #(.REG_OUT(1'b1), .CHECK(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .s       (s),
      .cout    (cout),
      .s_q     (s_q),
      .cout_q  (cout_q),
      .valid_q (valid_q),
      .err     (err)
   );

   // 9-bit ripple add/sub chain, side-band disabled
   logic [8:0] ca;
   logic [8:0] cb;
   logic       sub;
   wire  [9:0] carry;
   wire  [8:0] csum;
   wire  [8:0] c_sq;
   wire  [8:0] c_cq;
   wire  [8:0] c_vq;
   wire  [8:0] c_err;

   assign carry[0] = sub;

   for (genvar i = 0; i < 9; i++) begin : g_chain
      full_adder #(.REG_OUT(1'b0), .CHECK(1'b0)) u_fa (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .a       (ca[i]),
         .b       (cb[i] ^ sub),
         .cin     (carry[i]),
         .s       (csum[i]),
         .cout    (carry[i+1]),
         .s_q     (c_sq[i]),
         .cout_q  (c_cq[i]),
         .valid_q (c_vq[i]),
         .err     (c_err[i])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {cout,s} is the 2-bit arithmetic sum of the three input bits.
   function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
      int t;
      t = int'(x) + int'(y) + int'(z);
      return t[1:0];
   endfunction

   // Advance the registered-output model across one rising edge.
   task automatic model_edge();
      logic [1:0] r;
      r = ref_add(a, b, cin);
      if (rst) begin
         exp_sq = 1'b0;
         exp_cq = 1'b0;
         exp_v  = 1'b0;
      end else if (en) begin
         exp_sq = r[0];
         exp_cq = r[1];
         exp_v  = 1'b1;
      end else begin
         exp_v  = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
      a   = 1'b1;
      b   = 1'b1;
      cin = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      total_cnt++;
      if ({s_q, cout_q, valid_q, err} !== 4'b0000)
         $display("FAIL reset: {s_q,cout_q,valid_q,err}=%b expected 0000", {s_q, cout_q, valid_q, err});
      else
         pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
   endtask

   task automatic test_truth_table();
      logic [1:0] r;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         {a, b, cin} = 3'(i);
         #1;
         r = ref_add(a, b, cin);
         total_cnt++;
         if ({cout, s} !== r)
            $display("FAIL truth_table: in=%0d {cout,s}=%b expected %b", i, {cout, s}, r);
         else
            pass_cnt++;
      end
      @(negedge clk);
      {a, b, cin} = 3'b111;
      #1;
      total_cnt++;
      if ({s, cout} !== 2'b11)
         $display("FAIL max_case: {s,cout}=%b expected 11", {s, cout});
      else
         pass_cnt++;
      {a, b, cin} = 3'b000;
      #1;
      total_cnt++;
      if ({s, cout} !== 2'b00)
         $display("FAIL zero_case: {s,cout}=%b expected 00", {s, cout});
      else
         pass_cnt++;
   endtask

   task automatic test_chain();
      logic [8:0] exp;
      logic [8:0] va [3];
      logic [8:0] vb [3];
      logic       vs [3];
      va[0] = 9'd1; vb[0] = 9'd1; vs[0] = 1'b0;
      va[1] = 9'd5; vb[1] = 9'd2; vs[1] = 1'b0;
      va[2] = 9'd0; vb[2] = 9'd3; vs[2] = 1'b1;
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         if (i < 3) begin
            ca  = va[i];
            cb  = vb[i];
            sub = vs[i];
         end else begin
            ca  = 9'($urandom_range(0, 511));
            cb  = 9'($urandom_range(0, 511));
            sub = 1'($urandom_range(0, 1));
         end
         exp = sub ? 9'((int'(ca) - int'(cb)) % 512) : 9'((int'(ca) + int'(cb)) % 512);
         #1;
         total_cnt++;
         if (csum !== exp)
            $display("FAIL chain: a=%0d b=%0d sub=%0d sum=%h expected %h", ca, cb, sub, csum, exp);
         else
            pass_cnt++;
      end
      total_cnt++;
      if ({c_sq, c_cq, c_vq, c_err} !== 36'd0)
         $display("FAIL chain_tied: side-band=%h expected 0", {c_sq, c_cq, c_vq, c_err});
      else
         pass_cnt++;
   endtask

   task automatic test_registered_latency();
      @(negedge clk);
      en = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      total_cnt++;
      if ({s_q, cout_q, valid_q} !== 3'b011)
         $display("FAIL latency_capture: {s_q,cout_q,valid_q}=%b expected 011", {s_q, cout_q, valid_q});
      else
         pass_cnt++;
      @(negedge clk);
      en = 1'b0; a = 1'b1; b = 1'b0; cin = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      total_cnt++;
      if ({s_q, cout_q, valid_q} !== 3'b010)
         $display("FAIL latency_hold: {s_q,cout_q,valid_q}=%b expected 010", {s_q, cout_q, valid_q});
      else
         pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         en  = (i < 10) ? 1'b1 : 1'($urandom_range(0, 1));
         a   = 1'($urandom);
         b   = 1'($urandom);
         cin = 1'($urandom);
         @(posedge clk);
         model_edge();
         #1;
         total_cnt++;
         if ({s_q, cout_q, valid_q, err} !== {exp_sq, exp_cq, exp_v, 1'b0})
            $display("FAIL back_to_back[%0d]: {s_q,cout_q,valid_q,err}=%b expected %b",
                     i, {s_q, cout_q, valid_q, err}, {exp_sq, exp_cq, exp_v, 1'b0});
         else
            pass_cnt++;
      end
   endtask

   task automatic test_reset_priority();
      logic [1:0] r;
      @(negedge clk);
      en = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b0;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      rst = 1'b1; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         {a, b, cin} = 3'($urandom_range(0, 7));
         #1;
         r = ref_add(a, b, cin);
         total_cnt++;
         if ({cout, s} !== r)
            $display("FAIL comb_in_reset: {cout,s}=%b expected %b", {cout, s}, r);
         else
            pass_cnt++;
      end
      a = 1'b1; b = 1'b1; cin = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      total_cnt++;
      if ({s_q, cout_q, valid_q, err} !== 4'b0000)
         $display("FAIL reset_priority: {s_q,cout_q,valid_q,err}=%b expected 0000", {s_q, cout_q, valid_q, err});
      else
         pass_cnt++;
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
   endtask

   task automatic test_checker_clean();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         en = 1'b1;
         {a, b, cin} = 3'(i);
         @(posedge clk);
         model_edge();
      end
      #1;
      total_cnt++;
      if (err !== 1'b0)
         $display("FAIL checker_clean: err=%b expected 0", err);
      else
         pass_cnt++;
   endtask

   task automatic test_checker_force();
      @(negedge clk);
      force dut.g_check.s_ref_s = 1'b0;
      en = 1'b1; a = 1'b1; b = 1'b0; cin = 1'b0;
      @(posedge clk);
      #1;
      total_cnt++;
      if (err !== 1'b1)
         $display("FAIL checker_detect: err=%b expected 1", err);
      else
         pass_cnt++;
      @(negedge clk);
      release dut.g_check.s_ref_s;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en = 1'($urandom_range(0, 1));
         {a, b, cin} = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         total_cnt++;
         if (err !== 1'b1)
            $display("FAIL checker_sticky[%0d]: err=%b expected 1", i, err);
         else
            pass_cnt++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (err !== 1'b0)
         $display("FAIL checker_clear: err=%b expected 0", err);
      else
         pass_cnt++;
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      exp_sq = 1'b0; exp_cq = 1'b0; exp_v = 1'b0;
      rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; cin = 1'b0;
      ca = 9'd0; cb = 9'd0; sub = 1'b0;
      test_reset();
      test_truth_table();
      test_chain();
      test_registered_latency();
      test_back_to_back();
      test_reset_priority();
      test_checker_clean();
      test_checker_force();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
